gen_txen_frame: RTL and testbench

- Parametrised successor to the single-shot txen/DAT generator in the Lab406AD transmit path.
- On a start pulse it emits one transmit frame: one command word (CW) followed by 0..N_MAX data words (DW). Each word occupies a fixed slot of WORD_CYC clocks.
- txen is held high for the whole frame and gates the downstream serialiser/Manchester encoder.
- Data words come from an internal counter pattern or from an external source with a request handshake. A programmable guard gap separates frames.

---
 rtl/gen_txen_frame.sv | 224 ++++++++++++++++++++++
 tb/tb_gen_txen_frame.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_txen_frame.sv
// Transmit frame generator: emits one command word followed by 0..N_MAX data words
// per accepted start, holding txen high across the frame, then inserts a guard gap.
// Latency: frame begins the cycle after the accepting edge; no backpressure (dw_in is zero-latency).
`timescale 1ns/1ps

module gen_txen_frame #(
  parameter int W        = 16,
  parameter int N_MAX    = 32,
  parameter int NW       = 6,
  parameter int WORD_CYC = 20,
  parameter int GAP_CYC  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st,
  input  logic          mode,
  input  logic [W-1:0]  cw_in,
  input  logic [NW-1:0] n_dw,
  input  logic [W-1:0]  dw_seed,
  input  logic [W-1:0]  dw_in,
  output logic          dw_req,
  output logic          txen,
  output logic [W-1:0]  DAT,
  output logic [W-1:0]  CW_TX,
  output logic [W-1:0]  DW_TX,
  output logic          word_stb,
  output logic          busy,
  output logic          done,
  output logic          st_ovr
);

  // One counter serves both the word slots and the guard gap, so size it for the longer.
  localparam int CMAX = (WORD_CYC > GAP_CYC) ? WORD_CYC : GAP_CYC;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0] SLOT_LAST = CNTW'(WORD_CYC - 1);
  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP_CYC - 1);
  localparam logic [NW-1:0]   NMAX_V    = NW'(N_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CW   = 2'd1,
    S_DW   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [CNTW-1:0] cnt;
  logic [NW-1:0]   idx;
  logic [NW-1:0]   n_lat;
  logic            mode_lat;
  logic [W-1:0]    cw_tx_r;
  logic [W-1:0]    dw_tx_r;
  logic [W-1:0]    pat;
  logic            ovr;

  logic            accept;
  logic            slot_end;
  logic            gap_end;
  logic            last_word;
  logic            next_dw;
  logic            cnt_clr;

  // Decode of slot boundaries and whether another data word follows the current slot.
  always_comb begin
    accept    = 1'b0;
    slot_end  = 1'b0;
    gap_end   = 1'b0;
    last_word = 1'b0;
    next_dw   = 1'b0;
    cnt_clr   = 1'b0;

    accept    = (state == S_IDLE) && st;
    slot_end  = (cnt == SLOT_LAST);
    gap_end   = (cnt == GAP_LAST);
    last_word = (idx == (n_lat - NW'(1)));

    // A data word is loaded at the end of the CW slot (if any are requested)
    // and at the end of every DW slot except the last one.
    if (slot_end) begin
      if (state == S_CW) begin
        next_dw = (n_lat != '0);
      end else if (state == S_DW) begin
        next_dw = !last_word;
      end
    end

    // Counter restarts at every slot boundary, on entry to the gap, and idles at 0.
    cnt_clr = (state == S_IDLE)
           || (((state == S_CW) || (state == S_DW)) && slot_end)
           || ((state == S_GAP) && gap_end);
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and frame outputs, all decoded from the current state and counter.
  always_comb begin
    state_nxt = state;
    txen      = 1'b0;
    busy      = 1'b0;
    word_stb  = 1'b0;
    done      = 1'b0;
    dw_req    = 1'b0;
    DAT       = '0;

    case (state)
      S_IDLE: begin
        if (st) begin
          state_nxt = S_CW;
        end
      end

      S_CW: begin
        txen     = 1'b1;
        busy     = 1'b1;
        word_stb = (cnt == '0);
        DAT      = cw_tx_r;
        dw_req   = mode_lat && next_dw;
        if (slot_end) begin
          state_nxt = (n_lat == '0) ? S_GAP : S_DW;
        end
      end

      S_DW: begin
        txen     = 1'b1;
        busy     = 1'b1;
        word_stb = (cnt == '0);
        DAT      = dw_tx_r;
        dw_req   = mode_lat && next_dw;
        if (slot_end && last_word) begin
          state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        busy = 1'b1;
        done = (cnt == '0);
        if (gap_end) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Shared slot / gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNTW'(1);
    end
  end

  // Data-word index within the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (slot_end && (state == S_CW)) begin
      idx <= '0;
    end else if (slot_end && (state == S_DW) && !last_word) begin
      idx <= idx + NW'(1);
    end
  end

  // Frame parameters captured on the accepting edge; count is clamped to N_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_tx_r  <= '0;
      n_lat    <= '0;
      mode_lat <= 1'b0;
    end else if (accept) begin
      cw_tx_r  <= cw_in;
      n_lat    <= (n_dw > NMAX_V) ? NMAX_V : n_dw;
      mode_lat <= mode;
    end
  end

  // Data word load at each DW slot start: running counter pattern or the external word
  // sampled on the same edge as its request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_tx_r <= '0;
      pat     <= '0;
    end else if (accept) begin
      pat <= dw_seed;
    end else if (next_dw) begin
      dw_tx_r <= mode_lat ? dw_in : pat;
      pat     <= pat + W'(1);
    end
  end

  // Sticky overrun flag: any start seen while a frame or gap is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (accept) begin
      ovr <= 1'b0;
    end else if (st && (state != S_IDLE)) begin
      ovr <= 1'b1;
    end
  end

  assign CW_TX  = cw_tx_r;
  assign DW_TX  = dw_tx_r;
  assign st_ovr = ovr;

endmodule

// File: tb/tb_gen_txen_frame.sv
// Bench for gen_txen_frame: directed frames plus randomized starts, compared every cycle
// against a frame-timeline model; literal checks pin the model on the hand-worked cases.
`timescale 1ns/1ps

module tb_gen_txen_frame;

  localparam int W     = 16;
  localparam int N_MAX = 32;
  localparam int NW    = 6;
  localparam int WC    = 4;
  localparam int GC    = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          st      = 1'b0;
  logic          mode    = 1'b0;
  logic [W-1:0]  cw_in   = '0;
  logic [NW-1:0] n_dw    = '0;
  logic [W-1:0]  dw_seed = '0;
  logic [W-1:0]  dw_in   = '0;
  logic          dw_req, txen, word_stb, busy, done, st_ovr;
  logic [W-1:0]  DAT, CW_TX, DW_TX;

  gen_txen_frame #(.W(W), .N_MAX(N_MAX), .NW(NW), .WORD_CYC(WC), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .mode(mode), .cw_in(cw_in), .n_dw(n_dw),
    .dw_seed(dw_seed), .dw_in(dw_in), .dw_req(dw_req), .txen(txen), .DAT(DAT),
    .CW_TX(CW_TX), .DW_TX(DW_TX), .word_stb(word_stb), .busy(busy), .done(done),
    .st_ovr(st_ovr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: frame as a timeline ----------------
  // m_t counts cycles since txen rise; frame occupies WC*(1+n) cycles, gap GC more.
  bit           m_act  = 1'b0;
  int           m_t    = 0;
  int           m_n    = 0;
  bit           m_mode = 1'b0;
  bit           m_ovr  = 1'b0;
  logic [W-1:0] m_cw   = '0;
  logic [W-1:0] m_dwtx = '0;
  logic [W-1:0] m_words [N_MAX];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_t = 0; m_n = 0; m_mode = 1'b0; m_ovr = 1'b0;
      m_cw = '0; m_dwtx = '0;
    end else if (m_act) begin
      if (st) m_ovr = 1'b1;
      // external word for slot s+1 is taken at the end of slot s
      if (m_mode && (m_t < WC*(1+m_n)) && (m_t % WC == WC-1) && (m_t / WC < m_n))
        m_words[m_t / WC] = dw_in;
      m_t++;
      if (m_t == WC*(1+m_n) + GC) m_act = 1'b0;
      else if ((m_t < WC*(1+m_n)) && (m_t % WC == 0) && (m_t >= WC))
        m_dwtx = m_words[m_t / WC - 1];
    end else if (st) begin
      m_act = 1'b1; m_t = 0; m_ovr = 1'b0; m_cw = cw_in; m_mode = mode;
      m_n = (int'(n_dw) > N_MAX) ? N_MAX : int'(n_dw);
      for (int k = 0; k < N_MAX; k++) m_words[k] = dw_seed + W'(k);
    end
  end

  // ---------------- per-cycle compare + frame log ----------------
  int           cur_len = 0, last_len = 0, cur_stb = 0, last_stb = 0;
  int           low_run = 0, last_low = 0;
  logic [W-1:0] cur_dat[$], last_dat[$];
  int           cur_req[$], last_req[$];

  always @(negedge clk) begin
    logic         e_txen, e_busy, e_stb, e_done, e_req;
    logic [W-1:0] e_dat;
    int           len;
    e_txen = 1'b0; e_busy = 1'b0; e_stb = 1'b0; e_done = 1'b0; e_req = 1'b0; e_dat = '0;
    len = WC*(1+m_n);
    if (m_act) begin
      e_busy = 1'b1;
      if (m_t < len) begin
        e_txen = 1'b1;
        e_stb  = (m_t % WC == 0);
        if (m_t < WC) e_dat = m_cw;
        else          e_dat = m_words[m_t / WC - 1];
        e_req  = m_mode && (m_t % WC == WC-1) && (m_t / WC < m_n);
      end else begin
        e_done = (m_t == len);
      end
    end
    chk("txen",     32'(txen),     32'(e_txen));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("word_stb", 32'(word_stb), 32'(e_stb));
    chk("done",     32'(done),     32'(e_done));
    chk("dw_req",   32'(dw_req),   32'(e_req));
    chk("DAT",      32'(DAT),      32'(e_dat));
    chk("CW_TX",    32'(CW_TX),    32'(m_cw));
    chk("DW_TX",    32'(DW_TX),    32'(m_dwtx));
    chk("st_ovr",   32'(st_ovr),   32'(m_ovr));

    if (!rst_n) begin
      cur_len = 0; cur_stb = 0; low_run = 0; cur_dat.delete(); cur_req.delete();
    end else if (txen) begin
      if (cur_len == 0) last_low = low_run;
      cur_dat.push_back(DAT);
      if (word_stb) cur_stb++;
      if (dw_req) cur_req.push_back(cur_len);
      cur_len++;
      low_run = 0;
    end else begin
      if (cur_len > 0) begin
        last_len = cur_len; last_stb = cur_stb; last_dat = cur_dat; last_req = cur_req;
        cur_len = 0; cur_stb = 0; cur_dat.delete(); cur_req.delete();
      end
      low_run++;
    end
  end

  function automatic logic [W-1:0] ldat(input int i);
    if (i < last_dat.size()) return last_dat[i];
    return 'x;
  endfunction

  function automatic int lreq(input int i);
    if (i < last_req.size()) return last_req[i];
    return -1;
  endfunction

  // ---------------- external data source ----------------
  logic [W-1:0] ext_q[$];
  always @(posedge clk) begin
    #2;
    if (dw_req && ext_q.size() > 0) dw_in = ext_q.pop_front();
    else                            dw_in = W'($urandom);
  end

  // ---------------- stimulus ----------------
  task automatic scramble();
    cw_in = W'($urandom); n_dw = NW'($urandom); dw_seed = W'($urandom);
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic go(input logic [W-1:0] c, input int n, input logic [W-1:0] s, input logic m);
    @(posedge clk); #2;
    st = 1'b1; cw_in = c; n_dw = NW'(n); dw_seed = s; mode = m;
    @(posedge clk); #2;
    st = 1'b0; scramble();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #49;
    chk("rst txen",   32'(txen),   32'h0);
    chk("rst DAT",    32'(DAT),    32'h0);
    chk("rst busy",   32'(busy),   32'h0);
    chk("rst CW_TX",  32'(CW_TX),  32'h0);
    chk("rst DW_TX",  32'(DW_TX),  32'h0);
    chk("rst st_ovr", 32'(st_ovr), 32'h0);
    #52 rst_n = 1'b1;
    cycles(3);

    // CW-only frame
    go(16'h1234, 0, 16'h0000, 1'b0);
    cycles(WC + GC + 3);
    chk("n0 len",  32'(last_len), 32'd4);
    chk("n0 stb",  32'(last_stb), 32'd1);
    chk("n0 dat0", 32'(ldat(0)),  32'h1234);
    chk("n0 dat3", 32'(ldat(3)),  32'h1234);

    // counter pattern with wrap
    go(16'h1234, 3, 16'hFFFE, 1'b0);
    cycles(4*WC + GC + 3);
    chk("cnt len",  32'(last_len), 32'd16);
    chk("cnt stb",  32'(last_stb), 32'd4);
    chk("cnt dw0",  32'(ldat(4)),  32'hFFFE);
    chk("cnt dw1",  32'(ldat(8)),  32'hFFFF);
    chk("cnt dw2",  32'(ldat(12)), 32'h0000);
    chk("cnt dw2e", 32'(ldat(15)), 32'h0000);

    // external source
    ext_q.push_back(16'hA5A5);
    ext_q.push_back(16'h5A5A);
    go(16'h00E1, 2, 16'h0000, 1'b1);
    cycles(3*WC + GC + 3);
    chk("ext req0",  32'(lreq(0)),  32'd3);
    chk("ext req1",  32'(lreq(1)),  32'd7);
    chk("ext nreq",  32'(last_req.size()), 32'd2);
    chk("ext dw0",   32'(ldat(4)),  32'hA5A5);
    chk("ext dw1",   32'(ldat(8)),  32'h5A5A);
    chk("ext DW_TX", 32'(DW_TX),    32'h5A5A);

    // start while busy: mid-frame and in the gap
    go(16'h0BAD, 1, 16'h0100, 1'b0);
    cycles(2); #2 st = 1'b1;
    @(posedge clk); #2 st = 1'b0;
    chk("ovr set", 32'(st_ovr), 32'h1);
    cycles(5); #2 st = 1'b1;
    @(posedge clk); #2 st = 1'b0;
    cycles(5);
    chk("ovr len",  32'(last_len), 32'd8);
    chk("ovr dw0",  32'(ldat(4)),  32'h0100);
    chk("ovr hold", 32'(st_ovr),   32'h1);
    go(16'h2222, 0, 16'h0000, 1'b0);
    chk("ovr clr", 32'(st_ovr), 32'h0);
    cycles(WC + GC + 3);

    // clamp
    go(16'hBEEF, 40, 16'h1000, 1'b0);
    cycles(33*WC + GC + 3);
    chk("clamp len",  32'(last_len), 32'd132);
    chk("clamp stb",  32'(last_stb), 32'd33);
    chk("clamp last", 32'(ldat(131)), 32'h101F);

    // held start gives back-to-back frames
    @(posedge clk); #2;
    st = 1'b1; cw_in = 16'h4444; n_dw = '0; mode = 1'b0;
    cycles(20); #2 st = 1'b0;
    cycles(WC + GC + 3);
    chk("b2b gap", 32'(last_low), 32'(GC + 1));
    chk("b2b len", 32'(last_len), 32'd4);

    // reset during DW slot 1
    go(16'hC0DE, 3, 16'h0010, 1'b0);
    cycles(9); #1 rst_n = 1'b0;
    #1;
    chk("arst txen", 32'(txen), 32'h0);
    chk("arst DAT",  32'(DAT),  32'h0);
    chk("arst busy", 32'(busy), 32'h0);
    chk("arst done", 32'(done), 32'h0);
    cycles(3); #2 rst_n = 1'b1;
    cycles(2);
    go(16'h7777, 0, 16'h0000, 1'b0);
    cycles(WC + GC + 3);
    chk("post rst dat0", 32'(ldat(0)),  32'h7777);
    chk("post rst len",  32'(last_len), 32'd4);

    // randomized starts, some overlapping busy
    for (int it = 0; it < 40; it++) begin
      int n, hold;
      n    = $urandom_range(0, 40);
      hold = $urandom_range(1, 12);
      @(posedge clk); #2;
      st = 1'b1; cw_in = W'($urandom); n_dw = NW'(n); dw_seed = W'($urandom);
      mode = 1'($urandom_range(0, 1));
      cycles(hold); #2;
      st = 1'b0; scramble();
      cycles($urandom_range(0, WC*(1+n) + GC + 6));
    end
    cycles(40*WC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
